// File: rtl/tx_fifo_top_if.sv
// tx_fifo_if: FIFO head presentation and consume handshake toward the tx framer
interface tx_fifo_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data;
  logic              eop;
  logic              valid;
  logic              consume;
  modport master (output data, eop, valid, input consume);
  modport slave  (input data, eop, valid, output consume);
endinterface

// File: rtl/tx_fifo_top.sv
// tx_fifo_top: first-word-fall-through SPI transmit FIFO with hysteretic host request and sticky error flags
module tx_fifo_top #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int LOW_MARK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     spi_data,
  input  logic            spi_data_strobe,
  output logic            spi_data_request,
  input  logic            go,
  tx_fifo_if.master       thr,
  input  logic            clear_flags,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            underflow,
  output logic            busy
);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] HI   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] LO   = (ADDR_W+1)'(LOW_MARK);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t            state;
  logic [DATA_W:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   nxt_level;
  logic [13:0]       unused_bits;
  logic strobe_prev, stb_edge, wr_ev, eop_nv, empty, full, pop, wr_ok, ovf_ev, udf_ev;
  assign unused_bits = spi_data[13:0];
  always_comb begin
    stb_edge  = spi_data_strobe & ~strobe_prev;
    wr_ev     = stb_edge & spi_data[14];
    eop_nv    = stb_edge & spi_data[15] & ~spi_data[14];
    empty     = level == '0;
    full      = level == FULL;
    pop       = thr.consume & ~empty;
    wr_ok     = wr_ev & (~full | thr.consume);
    ovf_ev    = wr_ev & full & ~thr.consume;
    udf_ev    = thr.consume & empty;
    nxt_level = level + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
  end
  assign thr.valid = ~empty;
  assign thr.data  = thr.valid ? mem[rptr][DATA_W-1:0] : '0;
  assign thr.eop   = thr.valid & mem[rptr][DATA_W];
  assign busy      = state != IDLE;
  // storage carries no reset; the head is masked while empty instead
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr] <= {spi_data[15], spi_data[DATA_W-1:0]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      strobe_prev      <= 1'b0;
      wptr             <= '0;
      rptr             <= '0;
      level            <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
      spi_data_request <= 1'b0;
      state            <= IDLE;
    end else begin
      strobe_prev <= spi_data_strobe;
      level       <= nxt_level;
      overflow    <= ovf_ev | (overflow & ~clear_flags);
      underflow   <= udf_ev | (underflow & ~clear_flags);
      if (wr_ok) wptr <= wptr + ADDR_W'(1);
      if (pop) rptr <= rptr + ADDR_W'(1);
      case (state)
        IDLE: if (go) begin
          state            <= FILL;
          spi_data_request <= 1'b1;
        end
        FILL: if ((wr_ok & spi_data[15]) | eop_nv) begin
          state            <= DRAIN;
          spi_data_request <= 1'b0;
        end else if (nxt_level >= HI) spi_data_request <= 1'b0;
        else if (nxt_level <= LO) spi_data_request <= 1'b1;
        DRAIN: begin
          spi_data_request <= 1'b0;
          if (empty & ~wr_ev) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
